// File: rtl/calc_pkg.sv
// Shared calculator datapath constants and the digit converter state encoding.
package calc_pkg;

  localparam int unsigned MAX_DIGITS       = 6;
  localparam int unsigned CNT_W            = 4;
  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned IDX_W            = $clog2(MAX_DIGITS + 1);
  localparam int unsigned DIGIT_BASE_DEC   = 0;
  localparam int unsigned DIGIT_BASE_ASCII = 48;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_check.sv
// Classifies one entry byte as a decimal digit and extracts its value.
module digit_check
  import calc_pkg::*;
#(
  parameter int unsigned DIGIT_BASE = DIGIT_BASE_DEC
) (
  input  logic [BYTE_W-1:0] byte_in,
  output logic              is_digit_c,
  output logic [3:0]        value_c
);

  logic [BYTE_W:0] diff;

  // A borrow out of the subtraction means the byte sits below the digit base.
  always_comb begin
    diff       = {1'b0, byte_in} - (BYTE_W + 1)'(DIGIT_BASE);
    is_digit_c = !diff[BYTE_W] && (diff[BYTE_W-1:0] <= BYTE_W'(9));
    value_c    = diff[3:0];
  end

endmodule

// File: rtl/digit_to_bin.sv
// Folds the snapshotted digit entries into an unsigned binary operand,
// one digit per clock, oldest digit first.
module digit_to_bin
  import calc_pkg::*;
#(
  parameter int unsigned DIGIT_BASE = DIGIT_BASE_DEC,
  parameter int unsigned OUT_W      = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic [BYTE_W-1:0] din0,
  input  logic [BYTE_W-1:0] din1,
  input  logic [BYTE_W-1:0] din2,
  input  logic [BYTE_W-1:0] din3,
  input  logic [BYTE_W-1:0] din4,
  input  logic [BYTE_W-1:0] din5,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  value,
  output logic              err,
  output logic              trunc
);

  state_t                               state;
  logic [MAX_DIGITS-1:0][BYTE_W-1:0]    snap;
  logic [OUT_W-1:0]                     acc;
  logic [IDX_W-1:0]                     idx;
  logic                                 err_n;
  logic                                 trunc_n;

  logic [IDX_W-1:0]  start_idx;
  logic [IDX_W-1:0]  cur_idx;
  logic [BYTE_W-1:0] cur_byte;
  logic              cur_ok;
  logic [3:0]        cur_val;

  always_comb begin
    start_idx = (count > CNT_W'(MAX_DIGITS)) ? IDX_W'(MAX_DIGITS) : IDX_W'(count);
    cur_idx   = idx - IDX_W'(1);
    cur_byte  = snap[cur_idx];
  end

  digit_check #(
    .DIGIT_BASE (DIGIT_BASE)
  ) u_digit_check (
    .byte_in    (cur_byte),
    .is_digit_c (cur_ok),
    .value_c    (cur_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      snap    <= '0;
      acc     <= '0;
      idx     <= '0;
      err_n   <= 1'b0;
      trunc_n <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      value   <= '0;
      err     <= 1'b0;
      trunc   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            snap    <= {din5, din4, din3, din2, din1, din0};
            acc     <= '0;
            idx     <= start_idx;
            trunc_n <= (count > CNT_W'(MAX_DIGITS));
            err_n   <= 1'b0;
            busy    <= 1'b1;
            state   <= (start_idx == '0) ? ST_DONE : ST_CONV;
          end
        end
        ST_CONV: begin
          // A non-digit aborts the fold; the operand reads back as zero.
          if (!cur_ok) begin
            err_n <= 1'b1;
            acc   <= '0;
            state <= ST_DONE;
          end else begin
            acc <= (acc << 3) + (acc << 1) + OUT_W'(cur_val);
            idx <= cur_idx;
            if (cur_idx == '0) state <= ST_DONE;
          end
        end
        ST_DONE: begin
          value <= acc;
          err   <= err_n;
          trunc <= trunc_n;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digit_to_bin.sv
// Randomised scoreboard bench for digit_to_bin, run on a decimal-coded and
// an ASCII-coded instance fed from the same entry bytes.
module tb_digit_to_bin;
  import calc_pkg::*;

  typedef logic [7:0] bytes_t [6];
  typedef struct {
    int unsigned value;
    bit          err;
    bit          trunc;
    int unsigned lat;
    int unsigned se;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  count;
  logic [7:0]  din0, din1, din2, din3, din4, din5;
  logic        busy0, done0, err0, trunc0;
  logic        busy48, done48, err48, trunc48;
  logic [19:0] value0, value48;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  exp_t        q0[$];
  exp_t        q48[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  digit_to_bin #(.DIGIT_BASE(0), .OUT_W(20)) dut0 (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3), .din4(din4), .din5(din5),
    .busy(busy0), .done(done0), .value(value0), .err(err0), .trunc(trunc0)
  );

  digit_to_bin #(.DIGIT_BASE(48), .OUT_W(20)) dut48 (
    .clk(clk), .rst(rst), .start(start), .count(count),
    .din0(din0), .din1(din1), .din2(din2), .din3(din3), .din4(din4), .din5(din5),
    .busy(busy48), .done(done48), .value(value48), .err(err48), .trunc(trunc48)
  );

  task automatic cmp(input string nm, input int unsigned got, input int unsigned want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, want, $time);
    end
  endtask

  // Reference: newest min(count,6) digits weighted by powers of ten; the
  // oldest used digit is consumed first, so a bad byte is found oldest-first.
  function automatic exp_t model(input int unsigned cnt, input bytes_t b, input int unsigned base);
    exp_t e;
    int unsigned k;
    int unsigned p;
    k       = (cnt > 6) ? 6 : cnt;
    e.trunc = (cnt > 6);
    e.err   = 1'b0;
    e.value = 0;
    e.lat   = k + 1;
    e.se    = 0;
    for (int i = int'(k) - 1; i >= 0; i--) begin
      if (int'(b[i]) < int'(base) || int'(b[i]) - int'(base) > 9) begin
        e.err = 1'b1;
        e.lat = k - i + 1;
        break;
      end
    end
    if (!e.err) begin
      p = 1;
      for (int i = 0; i < int'(k); i++) begin
        e.value = e.value + (int'(b[i]) - base) * p;
        p = p * 10;
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done0) begin
      if (q0.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL d0_unexpected_done: got done=1, expected no done (t=%0t)", $time);
      end else begin
        e = q0.pop_front();
        cmp("d0_value", 32'(value0), e.value);
        cmp("d0_err",   32'(err0),   32'(e.err));
        cmp("d0_trunc", 32'(trunc0), 32'(e.trunc));
        cmp("d0_latency", cyc - e.se, e.lat);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && done48) begin
      if (q48.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL d48_unexpected_done: got done=1, expected no done (t=%0t)", $time);
      end else begin
        e = q48.pop_front();
        cmp("d48_value", 32'(value48), e.value);
        cmp("d48_err",   32'(err48),   32'(e.err));
        cmp("d48_trunc", 32'(trunc48), 32'(e.trunc));
        cmp("d48_latency", cyc - e.se, e.lat);
      end
    end
  end

  task automatic drive_bytes(input bytes_t b);
    din0 = b[0]; din1 = b[1]; din2 = b[2];
    din3 = b[3]; din4 = b[4]; din5 = b[5];
  endtask

  task automatic run_conv(input int unsigned cnt, input bytes_t b, input bit noise);
    exp_t e0, e48;
    bit   seen0, seen48, noised;
    bytes_t junk;
    e0  = model(cnt, b, 0);
    e48 = model(cnt, b, 48);
    @(negedge clk);
    count = 4'(cnt);
    drive_bytes(b);
    start = 1'b1;
    e0.se  = cyc + 1;
    e48.se = cyc + 1;
    q0.push_back(e0);
    q48.push_back(e48);
    seen0 = 0; seen48 = 0; noised = 0;
    for (int t = 0; t < 20 && !(seen0 && seen48); t++) begin
      @(negedge clk);
      start = 1'b0;
      if (!seen0) begin
        if (done0) seen0 = 1; else cmp("d0_busy", 32'(busy0), 1);
      end
      if (!seen48) begin
        if (done48) seen48 = 1; else cmp("d48_busy", 32'(busy48), 1);
      end
      if (noise && !noised && !seen0 && !seen48) begin
        for (int i = 0; i < 6; i++) junk[i] = 8'($urandom_range(0, 9));
        drive_bytes(junk);
        start  = 1'b1;
        noised = 1;
      end
    end
    if (!(seen0 && seen48)) cmp("done_timeout", 0, 1);
  endtask

  task automatic check_idle_zero(input string tag);
    cmp({tag, "_d0_busy"},   32'(busy0),   0);
    cmp({tag, "_d0_done"},   32'(done0),   0);
    cmp({tag, "_d0_value"},  32'(value0),  0);
    cmp({tag, "_d0_err"},    32'(err0),    0);
    cmp({tag, "_d0_trunc"},  32'(trunc0),  0);
    cmp({tag, "_d48_busy"},  32'(busy48),  0);
    cmp({tag, "_d48_done"},  32'(done48),  0);
    cmp({tag, "_d48_value"}, 32'(value48), 0);
    cmp({tag, "_d48_err"},   32'(err48),   0);
    cmp({tag, "_d48_trunc"}, 32'(trunc48), 0);
  endtask

  initial begin
    bytes_t b;
    int unsigned cnt;
    int unsigned base;
    rst = 1'b1; start = 1'b0; count = '0;
    din0 = '0; din1 = '0; din2 = '0; din3 = '0; din4 = '0; din5 = '0;
    #12;
    check_idle_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    b = '{8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0};
    run_conv(3, b, 0);
    run_conv(0, b, 0);
    b = '{8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
    run_conv(9, b, 0);
    run_conv(6, b, 0);
    b = '{8'h2B, 8'h35, 8'h30, 8'h30, 8'h30, 8'h30};
    run_conv(2, b, 0);
    b = '{8'h36, 8'h35, 8'h34, 8'h33, 8'h32, 8'h31};
    run_conv(6, b, 0);
    run_conv(15, b, 0);
    b = '{8'd2, 8'd4, 8'd0, 8'd0, 8'd0, 8'd0};
    run_conv(2, b, 1);
    b = '{8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9};
    run_conv(6, b, 0);

    // Reset in the middle of a five-digit fold: outputs clear, no done.
    @(negedge clk);
    count = 4'd5;
    b = '{8'd5, 8'd4, 8'd3, 8'd2, 8'd1, 8'd0};
    drive_bytes(b);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    cmp("midconv_d0_busy", 32'(busy0), 1);
    rst = 1'b1;
    #1;
    check_idle_zero("midreset");
    q0.delete();
    q48.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    b = '{8'd7, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    run_conv(1, b, 0);

    for (int n = 0; n < 40; n++) begin
      base = ($urandom_range(0, 1) == 0) ? 0 : 48;
      cnt  = $urandom_range(0, 15);
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 9) == 0) b[i] = 8'($urandom_range(0, 255));
        else b[i] = 8'($urandom_range(0, 9) + base);
      end
      run_conv(cnt, b, ($urandom_range(0, 3) == 0));
    end

    repeat (10) @(negedge clk);
    cmp("d0_queue_drained",  q0.size(),  0);
    cmp("d48_queue_drained", q48.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/digit_to_bin.md
Name: digit_to_bin

Overview:
- Sequential converter downstream of the 6-entry digit shift register in the calculator datapath.
- On a start pulse, snapshots the six entry bytes and the entry count, then folds the entered digits into one unsigned binary operand (acc = acc*10 + digit), one digit per clock.
- Result feeds the ALU/operand latch; error and truncation flags feed the display/status logic.

Parameters:
- MAX_DIGITS, 6, number of digit entries supplied by the shift register (fixed by the upstream stage).
- DIGIT_BASE, 0, code of digit '0' (set to 48 for ASCII entry); digit value = byte - DIGIT_BASE.
- OUT_W, 20, result width; must be >= 20 so that 999999 fits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request; ignored unless state is IDLE.
- count  in  4  number of digits entered (upstream entry counter; may exceed 6).
- din0  in  8  newest entry (least significant digit).
- din1 .. din5  in  8 each  older entries; din5 is the oldest.
- busy  out  1  high in CONV and DONE.
- done  out  1  one-cycle pulse when value/err/trunc are updated.
- value  out  OUT_W  converted operand; holds until the next done.
- err  out  1  a non-digit byte was encountered in the last conversion.
- trunc  out  1  count exceeded MAX_DIGITS in the last conversion; only the 6 newest digits were used.

Behaviour:
- Reset (async): state=IDLE; busy=0, done=0, value=0, err=0, trunc=0; internal acc, idx and snapshot cleared.
- States: IDLE, CONV, DONE.
- IDLE + start:
  - Snapshot din0..din5 into internal registers; later upstream shifts have no effect.
  - acc=0; idx=min(count,6); trunc_n=(count>6); err_n=0.
  - Next state is DONE if idx==0, else CONV.
- CONV, once per cycle, with digit = snap[idx-1] - DIGIT_BASE:
  - If the byte < DIGIT_BASE or digit > 9: err_n=1, acc=0, next state DONE (abort).
  - Otherwise acc = (acc<<3) + (acc<<1) + digit, idx = idx-1; next state DONE when the new idx==0.
- DONE, one cycle:
  - value<=acc, err<=err_n, trunc<=trunc_n, done=1.
  - Next state IDLE.
- Latency: start sampled at edge N, k=min(count,6) digits, no error -> done high in cycle after edge N+k+1; count=0 -> done after edge N+1.
- Throughput: a new start is accepted in the first cycle after done.
- start while busy: ignored; no queuing.
- Arithmetic: unsigned; no overflow is possible with 6 digits and OUT_W>=20.
- Reset mid-conversion: abort immediately to the reset values; no done pulse.
- trunc and err may both be set; on err, value=0.

Decomposition:
- Package calc_pkg holds:
  - state encoding (IDLE, CONV, DONE);
  - MAX_DIGITS=6;
  - DIGIT_BASE defaults;
  - CNT_W=4, BYTE_W=8.
- Sub-module digit_check: combinational; byte in -> {is_digit, value[3:0]}, parameterised by DIGIT_BASE. It is shared later with the display decoder.
- Core FSM, snapshot, acc and idx stay in digit_to_bin.

Test Plan:
- Three digits, DIGIT_BASE=0: count=3, din2=1, din1=2, din0=3, start -> done 4 cycles later, value=123, err=0, trunc=0, busy high throughout.
- Empty entry: count=0, start -> done 1 cycle later, value=0, err=0, trunc=0.
- Full and truncated: count=9, din5..din0=9,8,7,6,5,4 -> value=987654, trunc=1, done after 7 cycles. Then count=6 with the same digits -> value=987654, trunc=0.
- Bad digit, DIGIT_BASE=48: count=2, din1=8'h35, din0=8'h2B -> done after processing din0, err=1, value=0.
- Snapshot and ignored start: start with count=2 (4,2); while busy, change din* and pulse start -> single done with value=42; no second done.
- Reset mid-CONV: assert rst during a count=5 conversion -> all outputs 0 immediately, no done. After release, a new conversion of count=1, din0=7 -> value=7.
